// File: rtl/bsg_pipeline_share_rr.sv
// Round-robin share of one stages_p-deep datapath among reqs_p requesters.
// Drives stage enables and input select, tracks tags, routes results back.
module bsg_pipeline_share_rr #(
  parameter int stages_p     = 3,
  parameter int reqs_p       = 2,
  parameter int tag_width_lp = (reqs_p > 1) ? $clog2(reqs_p) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [reqs_p-1:0]       v_i,
  output logic [reqs_p-1:0]       ready_and_o,
  output logic [reqs_p-1:0]       sel_one_hot_o,
  output logic [stages_p-1:0]     en_o,
  output logic [reqs_p-1:0]       v_o,
  input  logic [reqs_p-1:0]       ready_and_i,
  output logic [tag_width_lp-1:0] tag_o
);

  typedef logic [tag_width_lp-1:0] tag_t;

  logic [stages_p-1:0]            v_q, v_d;
  logic [stages_p-1:0][tag_width_lp-1:0] tag_q, tag_d;
  tag_t                           last_q, last_d;

  logic                           head_rdy;
  logic                           grant_v;
  tag_t                           winner;
  logic [stages_p-1:0]            full;
  logic [stages_p-1:0]            adv;
  logic [stages_p:0]              v_ext;
  logic [stages_p:0][tag_width_lp-1:0] tag_ext;

  // Round-robin pick: first requesting index after the last winner.
  always_comb begin
    logic found;
    int   idx;
    tag_t cand;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int i = 1; i <= reqs_p; i++) begin
      idx  = (int'(last_q) + i) % reqs_p;
      cand = tag_t'(idx);
      if (!found && v_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    grant_v = found;
  end

  // Collapse logic: a stage moves unless it and everything below is full
  // while the head result is stuck.
  always_comb begin
    head_rdy = ready_and_i[tag_q[0]];
    full[0]  = v_q[0];
    for (int i = 1; i < stages_p; i++) begin
      full[i] = full[i-1] & v_q[i];
    end
    adv     = {stages_p{head_rdy}} | ~full;
    v_ext   = {grant_v, v_q};
    tag_ext = {winner, tag_q};
    en_o    = v_ext[stages_p:1] & adv;
  end

  // Outputs toward requesters and the datapath input mux.
  always_comb begin
    sel_one_hot_o = '0;
    v_o           = '0;
    for (int k = 0; k < reqs_p; k++) begin
      sel_one_hot_o[k] = grant_v & (winner == tag_t'(k));
      v_o[k]           = v_q[0] & (tag_q[0] == tag_t'(k));
    end
    ready_and_o = sel_one_hot_o & {reqs_p{adv[stages_p-1]}};
    tag_o       = tag_q[0];
  end

  // Next-state for stage valids, tags and round-robin pointer.
  always_comb begin
    v_d    = v_q;
    tag_d  = tag_q;
    last_d = last_q;
    for (int i = 0; i < stages_p; i++) begin
      if (adv[i]) v_d[i] = v_ext[i+1];
      if (en_o[i]) tag_d[i] = tag_ext[i+1];
    end
    if (grant_v && adv[stages_p-1]) last_d = winner;
  end

  // State registers; reset drops all in-flight items.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q    <= '0;
      tag_q  <= '0;
      last_q <= tag_t'(reqs_p - 1);
    end else begin
      v_q    <= v_d;
      tag_q  <= tag_d;
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_bsg_pipeline_share_rr.sv
// Bench for bsg_pipeline_share_rr: directed cycle checks plus a
// scoreboard of accepted requester tags in arrival order.
module tb_bsg_pipeline_share_rr;

  localparam int S = 3;
  localparam int R = 2;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [R-1:0] v_i, ready_and_o, sel_one_hot_o, v_o, ready_and_i;
  logic [S-1:0] en_o;
  logic         tag_o;

  int n_run  = 0;
  int n_fail = 0;
  int sb[$];

  always #5 clk = ~clk;

  bsg_pipeline_share_rr #(.stages_p(S), .reqs_p(R)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .ready_and_o  (ready_and_o),
    .sel_one_hot_o(sel_one_hot_o),
    .en_o         (en_o),
    .v_o          (v_o),
    .ready_and_i  (ready_and_i),
    .tag_o        (tag_o)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_i     = 1'b1;
    v_i         = '0;
    ready_and_i = 2'b11;
    nxt();
    nxt();
    reset_i = 1'b0;
  endtask

  task automatic drain(input int n);
    v_i         = '0;
    ready_and_i = 2'b11;
    for (int i = 0; i < n; i++) nxt();
  endtask

  // Scoreboard: push on accept, pop and compare on consume.
  always @(negedge clk) begin
    int t;
    int e;
    if (reset_i) begin
      sb.delete();
    end else begin
      if (|v_o) begin
        t = v_o[1] ? 1 : 0;
        if (ready_and_i[t]) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("sb_tag", int'(tag_o), e);
            chk("sb_vo", int'(v_o), 1 << e);
          end
        end
      end
      for (int k = 0; k < R; k++) begin
        if (ready_and_o[k]) begin
          chk("acc_v", int'(v_i[k]), 1);
          sb.push_back(k);
        end
      end
    end
  end

  initial begin
    reset_i     = 1'b1;
    v_i         = '0;
    ready_and_i = '0;
    #1;
    do_reset();

    smp();
    chk("rst_vo", int'(v_o), 0);
    chk("rst_en", int'(en_o), 0);
    chk("rst_tag", int'(tag_o), 0);
    chk("rst_rdy", int'(ready_and_o), 0);
    nxt();

    // single item latency
    v_i = 2'b01;
    smp();
    chk("t1_rdy", int'(ready_and_o), 1);
    chk("t1_sel", int'(sel_one_hot_o), 1);
    chk("t1_en0", int'(en_o), 3'b100);
    nxt();
    v_i = '0;
    smp();
    chk("t1_en1", int'(en_o), 3'b010);
    chk("t1_vo1", int'(v_o), 0);
    nxt();
    smp();
    chk("t1_en2", int'(en_o), 3'b001);
    chk("t1_vo2", int'(v_o), 0);
    nxt();
    smp();
    chk("t1_vo3", int'(v_o), 1);
    chk("t1_tag3", int'(tag_o), 0);
    nxt();
    smp();
    chk("t1_vo4", int'(v_o), 0);
    nxt();

    // alternating full-rate stream
    do_reset();
    v_i = 2'b11;
    for (int c = 0; c < 10; c++) begin
      smp();
      chk("t2_rdy", int'(ready_and_o), (c % 2 == 0) ? 1 : 2);
      chk("t2_vo", int'(v_o), (c < 3) ? 0 : (((c - 3) % 2 == 0) ? 1 : 2));
      nxt();
    end
    drain(5);

    // capacity with stalled head
    do_reset();
    ready_and_i = 2'b00;
    v_i         = 2'b01;
    for (int c = 0; c < 5; c++) begin
      smp();
      chk("t3_rdy", int'(ready_and_o), (c < 3) ? 1 : 0);
      chk("t3_vo", int'(v_o), (c < 3) ? 0 : 1);
      if (c >= 3) chk("t3_en", int'(en_o), 0);
      nxt();
    end
    ready_and_i = 2'b01;
    smp();
    chk("t3_cons_rdy", int'(ready_and_o), 1);
    chk("t3_cons_en", int'(en_o), 3'b111);
    nxt();
    drain(5);

    // head-of-line block on requester 1
    do_reset();
    ready_and_i = 2'b01;
    v_i         = 2'b10;
    smp();
    chk("t4_acc1", int'(ready_and_o), 2);
    nxt();
    v_i = 2'b01;
    for (int c = 1; c < 5; c++) begin
      smp();
      chk("t4_rdy", int'(ready_and_o), (c < 3) ? 1 : 0);
      if (c >= 3) begin
        chk("t4_vo", int'(v_o), 2);
        chk("t4_en", int'(en_o), 0);
      end
      nxt();
    end
    v_i         = '0;
    ready_and_i = 2'b10;
    smp();
    chk("t4_drain_vo", int'(v_o), 2);
    nxt();
    smp();
    chk("t4_next_vo", int'(v_o), 1);
    chk("t4_next_en", int'(en_o), 0);
    nxt();
    drain(5);

    // bubble collapse keeps the stalled head tag
    do_reset();
    ready_and_i = 2'b00;
    v_i         = 2'b10;
    nxt();
    v_i = '0;
    nxt();
    v_i = 2'b01;
    nxt();
    v_i = '0;
    smp();
    chk("t5_vo", int'(v_o), 2);
    chk("t5_en", int'(en_o), 3'b010);
    nxt();
    smp();
    chk("t5_en2", int'(en_o), 0);
    chk("t5_vo2", int'(v_o), 2);
    chk("t5_tag", int'(tag_o), 1);
    nxt();
    drain(5);

    // reset with items in flight
    do_reset();
    ready_and_i = 2'b00;
    v_i         = 2'b11;
    nxt();
    nxt();
    nxt();
    smp();
    chk("t6_full_rdy", int'(ready_and_o), 0);
    nxt();
    reset_i = 1'b1;
    nxt();
    reset_i = 1'b0;
    smp();
    chk("t6_vo", int'(v_o), 0);
    chk("t6_rdy", int'(ready_and_o), 1);
    nxt();
    drain(5);

    smp();
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
